// File: rtl/pipe_ctrl.sv
// pipe_ctrl: elastic pipeline-register bank.
//
// STAGES slots of DATA_W bits, each with its own valid bit. Stage 0 is the
// youngest and takes words from the input port. Stage STAGES-1 is the oldest
// and drives the output port. A stage advances whenever it, or any stage
// above it, has an empty slot, or the downstream consumer is ready. This
// means bubbles get squeezed out while the bank is stalled. A ranged flush
// invalidates the youngest stages when a branch is taken. Occupancy and a
// saturating stall counter are reported alongside.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   in_valid/in_data/in_ready     upstream handshake (into stage 0)
//   out_valid/out_data/out_ready  downstream handshake (from oldest stage)
//   flush_i        squash request
//   flush_upto_i   squash stages 0..flush_upto_i inclusive
//   stage_valid_o  per-stage valid bits, bit 0 = youngest
//   occupancy_o    number of valid stages
//   stall_cnt_o    cycles with out_valid && !out_ready, saturating
module pipe_ctrl #(
  parameter int DATA_W = 288,
  parameter int STAGES = 4,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  flush_upto_i,
  output logic [STAGES-1:0] stage_valid_o,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [STAGES:0]   rdy;
  logic [31:0]       upto;
  logic              full_flush;

  assign upto       = 32'(flush_upto_i);
  assign full_flush = flush_i && (upto >= 32'(STAGES - 1));

  // rdy[k] is the unrolled form of !valid[k] || rdy[k+1]. A stage may move
  // when downstream is ready or when any slot at or above it is empty.
  // Each bit reduces the registered valids directly, so the chain has no
  // combinational loop.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = out_ready || (((~valid_q) >> k) != '0);
    end
  end

  always_comb begin
    logic src_v;
    valid_d = valid_q;
    data_d  = data_q;
    src_v   = 1'b0;

    // Stage 0 never takes a word while flushing, because the input
    // handshake is suppressed.
    if (rdy[0]) begin
      src_v      = in_valid && !flush_i;
      valid_d[0] = src_v;
      if (src_v) data_d[0] = in_data;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        src_v = valid_q[k-1];
        // The word leaving the last flushed stage is squashed in flight.
        if (flush_i && (32'(k) == upto + 32'd1)) src_v = 1'b0;
        valid_d[k] = src_v;
        if (src_v) data_d[k] = data_q[k-1];
      end
    end

    if (flush_i) begin
      for (int k = 0; k < STAGES; k++) begin
        if (32'(k) <= upto) valid_d[k] = 1'b0;
      end
    end
  end

  // out_valid is masked during a full flush, so a squashed oldest word is
  // never reported as consumed or as stalled.
  assign out_valid     = valid_q[STAGES-1] && !full_flush;
  assign out_data      = data_q[STAGES-1];
  assign in_ready      = rdy[0] && !flush_i;
  assign stage_valid_o = valid_q;
  assign stall_cnt_o   = stall_q;

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy_o = occupancy_o + OCC_W'(valid_q[k]);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      stall_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

endmodule
